// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolver: queue entry layout,
// bubble marker PC and the architectural next-PC computation.
package branch_pkg;

    localparam logic [31:0] INVALID_PC = 32'hfafafafa;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_next;
    } bp_entry_t;

    // Fall-through wraps naturally in 32 bits (0xfffffffc + 4 = 0).
    function automatic logic [31:0] bp_correct_next(
        input logic [31:0] pc,
        input logic        is_branch,
        input logic        taken,
        input logic [31:0] target
    );
        return (is_branch && taken) ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute/predictor-update bundle around the branch resolver.
// Handshake: a push happens in any cycle where pred_valid && pred_ready are both high at the clock edge.
interface branch_resolver_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pred_valid;
    logic [31:0]   pred_PC;
    logic [31:0]   pred_Next_PC;
    logic          pred_ready;
    logic          res_valid;
    logic          res_is_branch;
    logic          res_taken;
    logic [31:0]   res_target;
    logic          update;
    logic [31:0]   wrong_PC;
    logic          update_taken;
    logic [31:0]   update_PC;
    logic [31:0]   update_branch_PC;
    logic          flush;
    logic [CW-1:0] inflight;
    logic          resolve_error;

    modport slave (
        input  pred_valid, pred_PC, pred_Next_PC,
        input  res_valid, res_is_branch, res_taken, res_target,
        output pred_ready, update, wrong_PC, update_taken, update_PC,
        output update_branch_PC, flush, inflight, resolve_error
    );

    modport master (
        output pred_valid, pred_PC, pred_Next_PC,
        output res_valid, res_is_branch, res_taken, res_target,
        input  pred_ready, update, wrong_PC, update_taken, update_PC,
        input  update_branch_PC, flush, inflight, resolve_error
    );

endinterface

// File: rtl/bp_fifo.sv
// Circular FIFO of in-flight predictions; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module bp_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t wdata,
    output bp_entry_t rdata,
    output logic [AW:0] count,
    output logic      empty,
    output logic      full
);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    bp_entry_t   mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;

    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    // Clear dominates so a flush never leaves a half-updated queue behind.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Checks each resolved instruction against its queued prediction and emits a
// one-cycle predictor correction plus pipeline flush on a misprediction.
module branch_resolver #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] INVALID_PC = branch_pkg::INVALID_PC
) (
    input logic clk,
    input logic rstn,
    branch_resolver_if.slave bus
);
    import branch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    bp_entry_t   head, wr_entry;
    logic [AW:0] count;
    logic        empty, full;
    logic        pop, push, mispredict_now, pred_ready;
    logic        correct_taken;
    logic [31:0] correct_next;

    logic        update_q, update_taken_q, resolve_error_q;
    logic [31:0] wrong_pc_q, update_pc_q, update_branch_pc_q;

    // Resolves arriving during the update cycle belong to the squashed path.
    assign pop            = bus.res_valid && !update_q && !empty;
    assign correct_taken  = bus.res_is_branch && bus.res_taken;
    assign correct_next   = bp_correct_next(head.pc, bus.res_is_branch,
                                            bus.res_taken, bus.res_target);
    assign mispredict_now = pop && (correct_next != head.pred_next);
    assign pred_ready     = !full && !mispredict_now && !update_q;
    assign push           = bus.pred_valid && pred_ready && (bus.pred_PC != INVALID_PC);
    assign wr_entry       = '{pc: bus.pred_PC, pred_next: bus.pred_Next_PC};

    bp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .clear (mispredict_now),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            update_q           <= 1'b0;
            update_taken_q     <= 1'b0;
            wrong_pc_q         <= '0;
            update_pc_q        <= '0;
            update_branch_pc_q <= '0;
            resolve_error_q    <= 1'b0;
        end else begin
            update_q <= mispredict_now;
            if (mispredict_now) begin
                update_taken_q     <= correct_taken;
                wrong_pc_q         <= head.pred_next;
                update_pc_q        <= correct_next;
                update_branch_pc_q <= head.pc;
            end
            if (bus.res_valid && !update_q && empty) begin
                resolve_error_q <= 1'b1;
            end
        end
    end

    assign bus.pred_ready       = pred_ready;
    assign bus.update           = update_q;
    assign bus.flush            = update_q;
    assign bus.update_taken     = update_taken_q;
    assign bus.wrong_PC         = wrong_pc_q;
    assign bus.update_PC        = update_pc_q;
    assign bus.update_branch_PC = update_branch_pc_q;
    assign bus.inflight         = count;
    assign bus.resolve_error    = resolve_error_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: prediction queue, misprediction updates,
// full/empty boundaries, bubble pushes, PC wrap and mid-update reset.
module tb_branch_resolver;
    import branch_pkg::*;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    branch_resolver_if #(.DEPTH(8)) bus ();

    branch_resolver #(.DEPTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pred_valid    = 1'b0;
        bus.pred_PC       = '0;
        bus.pred_Next_PC  = '0;
        bus.res_valid     = 1'b0;
        bus.res_is_branch = 1'b0;
        bus.res_taken     = 1'b0;
        bus.res_target    = '0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [31:0] pred);
        bus.pred_valid   = 1'b1;
        bus.pred_PC      = pc;
        bus.pred_Next_PC = pred;
    endtask

    task automatic set_res(input logic br, input logic tk, input logic [31:0] tgt);
        bus.res_valid     = 1'b1;
        bus.res_is_branch = br;
        bus.res_taken     = tk;
        bus.res_target    = tgt;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] pred);
        set_push(pc, pred);
        tick();
        idle_inputs();
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
        set_res(br, tk, tgt);
        tick();
        idle_inputs();
    endtask

    task automatic chk_update(input string tag, input logic [31:0] wrong, input logic [31:0] upc,
                              input logic tk, input logic [31:0] bpc);
        chk({tag, "_update"}, 32'(bus.update), 32'd1);
        chk({tag, "_flush"}, 32'(bus.flush), 32'd1);
        chk({tag, "_wrong_PC"}, bus.wrong_PC, wrong);
        chk({tag, "_update_PC"}, bus.update_PC, upc);
        chk({tag, "_update_taken"}, 32'(bus.update_taken), 32'(tk));
        chk({tag, "_branch_PC"}, bus.update_branch_PC, bpc);
        chk({tag, "_inflight"}, 32'(bus.inflight), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rstn = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_inflight", 32'(bus.inflight), 32'd0);
        chk("rst_update", 32'(bus.update), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_update_taken", 32'(bus.update_taken), 32'd0);
        chk("rst_wrong_PC", bus.wrong_PC, 32'd0);
        chk("rst_update_PC", bus.update_PC, 32'd0);
        chk("rst_branch_PC", bus.update_branch_PC, 32'd0);
        chk("rst_resolve_error", 32'(bus.resolve_error), 32'd0);
        chk("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Correct not-branch prediction
        push(32'h100, 32'h104);
        chk("nb_inflight1", 32'(bus.inflight), 32'd1);
        resolve(1'b0, 1'b0, 32'h0);
        chk("nb_update", 32'(bus.update), 32'd0);
        chk("nb_inflight0", 32'(bus.inflight), 32'd0);

        // Taken branch predicted as fall-through
        push(32'h200, 32'h204);
        resolve(1'b1, 1'b1, 32'h300);
        chk_update("tk", 32'h204, 32'h300, 1'b1, 32'h200);
        chk("tk_ready_in_update", 32'(bus.pred_ready), 32'd0);
        tick();
        chk("tk_update_drop", 32'(bus.update), 32'd0);
        chk("tk_hold_wrong_PC", bus.wrong_PC, 32'h204);
        chk("tk_ready_after", 32'(bus.pred_ready), 32'd1);

        // Correctly predicted taken; not-branch with stray taken bit
        push(32'h300, 32'h400);
        resolve(1'b1, 1'b1, 32'h400);
        chk("tk_ok_update", 32'(bus.update), 32'd0);
        push(32'h10, 32'h14);
        resolve(1'b0, 1'b1, 32'h99);
        chk("nb_stray_taken_update", 32'(bus.update), 32'd0);
        chk("nb_stray_inflight", 32'(bus.inflight), 32'd0);

        // Branch predicted taken, actually not taken
        push(32'h400, 32'h800);
        resolve(1'b1, 1'b0, 32'h800);
        chk_update("ntk", 32'h800, 32'h404, 1'b0, 32'h400);
        tick();

        // Three entries, second mispredicted; wrong-path pushes dropped
        push(32'h104, 32'h108);
        push(32'h108, 32'h500);
        push(32'h500, 32'h504);
        chk("m3_inflight3", 32'(bus.inflight), 32'd3);
        resolve(1'b0, 1'b0, 32'h0);
        chk("m3_first_ok", 32'(bus.update), 32'd0);
        chk("m3_inflight2", 32'(bus.inflight), 32'd2);
        set_res(1'b0, 1'b0, 32'h0);
        set_push(32'h600, 32'h604);
        #1;
        chk("m3_ready_mispredict", 32'(bus.pred_ready), 32'd0);
        tick();
        chk_update("m3", 32'h500, 32'h10C, 1'b0, 32'h108);
        set_push(32'h604, 32'h608);
        #1;
        chk("m3_ready_update", 32'(bus.pred_ready), 32'd0);
        tick();
        idle_inputs();
        chk("m3_inflight_after", 32'(bus.inflight), 32'd0);
        chk("m3_single_update", 32'(bus.update), 32'd0);
        chk("m3_res_in_update_ignored", 32'(bus.resolve_error), 32'd0);

        // Fill to DEPTH, simultaneous push/pop, overflow drop
        for (int i = 0; i < 7; i++) begin
            push(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i));
        end
        chk("full_inflight7", 32'(bus.inflight), 32'd7);
        set_push(32'h101C, 32'h1020);
        set_res(1'b0, 1'b0, 32'h0);
        tick();
        idle_inputs();
        chk("pushpop_inflight7", 32'(bus.inflight), 32'd7);
        push(32'h1020, 32'h1024);
        chk("full_inflight8", 32'(bus.inflight), 32'd8);
        chk("full_ready", 32'(bus.pred_ready), 32'd0);
        push(32'h1024, 32'h1028);
        chk("full_drop9", 32'(bus.inflight), 32'd8);
        set_push(32'h1024, 32'h1028);
        set_res(1'b0, 1'b0, 32'h0);
        #1;
        chk("full_pop_ready", 32'(bus.pred_ready), 32'd0);
        tick();
        idle_inputs();
        chk("full_pop_inflight7", 32'(bus.inflight), 32'd7);
        for (int i = 0; i < 7; i++) begin
            resolve(1'b0, 1'b0, 32'h0);
            chk("drain_update", 32'(bus.update), 32'd0);
        end
        chk("drain_inflight", 32'(bus.inflight), 32'd0);

        // Resolve on empty queue is sticky
        resolve(1'b0, 1'b0, 32'h0);
        chk("empty_res_error", 32'(bus.resolve_error), 32'd1);
        chk("empty_res_update", 32'(bus.update), 32'd0);
        tick();
        tick();
        chk("empty_res_sticky", 32'(bus.resolve_error), 32'd1);

        // Bubble push is not recorded
        push(INVALID_PC, 32'h1234);
        chk("bubble_inflight", 32'(bus.inflight), 32'd0);
        chk("bubble_ready", 32'(bus.pred_ready), 32'd1);

        // 32-bit wrap of the fall-through PC
        push(32'hfffffffc, 32'h0);
        resolve(1'b0, 1'b0, 32'h0);
        chk("wrap_update", 32'(bus.update), 32'd0);
        chk("wrap_inflight", 32'(bus.inflight), 32'd0);

        // Reset lands in the mispredict cycle: update never appears
        push(32'h700, 32'h704);
        set_res(1'b1, 1'b1, 32'h900);
        rstn = 1'b0;
        #2;
        chk("arst_inflight", 32'(bus.inflight), 32'd0);
        chk("arst_resolve_error", 32'(bus.resolve_error), 32'd0);
        chk("arst_wrong_PC", bus.wrong_PC, 32'd0);
        tick();
        idle_inputs();
        chk("arst_update", 32'(bus.update), 32'd0);
        rstn = 1'b1;
        tick();
        chk("arst_update_after", 32'(bus.update), 32'd0);
        chk("arst_flush_after", 32'(bus.flush), 32'd0);
        chk("arst_update_PC", bus.update_PC, 32'd0);
        chk("arst_branch_PC", bus.update_branch_PC, 32'd0);
        chk("arst_update_taken", 32'(bus.update_taken), 32'd0);
        chk("arst_ready", 32'(bus.pred_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Tracks every fetched instruction's predicted next PC in an in-order queue, checks each prediction against the actual outcome reported by execute, and drives the branch predictor's correction port (`update`, `wrong_PC`, `update_taken`, `update_PC`) plus a pipeline flush on a misprediction. It sits between fetch/execute and the branch predictor, and is the producer side of the predictor's update interface.

## Interface
- `DEPTH`, 8: in-flight queue entries; power of two, ≥2.
- `INVALID_PC`, 32'hfafafafa: bubble marker PC; pushes carrying it are not recorded.

- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `pred_valid`  in  1  fetch issues an instruction with its prediction.
- `pred_PC`  in  32  PC of the fetched instruction.
- `pred_Next_PC`  in  32  predictor's Next_PC for that PC.
- `pred_ready`  out  1  push accepted this cycle.
- `res_valid`  in  1  execute resolves the oldest in-flight instruction.
- `res_is_branch`  in  1  resolved instruction is a control transfer.
- `res_taken`  in  1  actual direction; ignored when `!res_is_branch`.
- `res_target`  in  32  actual target when taken.
- `update`  out  1  one-cycle misprediction pulse to predictor.
- `wrong_PC`  out  32  mispredicted Next_PC value.
- `update_taken`  out  1  correct direction.
- `update_PC`  out  32  correct next PC.
- `update_branch_PC`  out  32  PC of the mispredicted instruction.
- `flush`  out  1  squash younger pipeline state; equals `update`.
- `inflight`  out  $clog2(DEPTH)+1  occupied entries.
- `resolve_error`  out  1  sticky: resolve arrived with queue empty.

## Operation
- Entry = {pc, pred_next}. Push when `pred_valid && pred_ready && pred_PC != INVALID_PC`; an INVALID_PC push is consumed without allocation.
- `pred_ready` = `inflight < DEPTH && !mispredict_now && !update` (combinational). Pushes in the mispredict cycle and the following update cycle are wrong-path and are dropped.
- Resolve pops the head. Correct next = `res_is_branch && res_taken ? res_target : pc + 32'd4`, with 32-bit wrap (32'hfffffffc + 4 = 0).
- Mismatch when correct next != pred_next, which covers a non-branch predicted as not PC+4 (`update_taken`=0, `update_PC`=pc+4).
- On mismatch, at the next edge: the whole queue clears, `inflight`=0, and `update`/`flush` go high for one cycle with `wrong_PC`=pred_next, `update_PC`=correct next, `update_taken`=`res_is_branch && res_taken`, `update_branch_PC`=pc. Payload outputs hold their value until the next update.
- On match: the entry pops and no outputs change.
- With `res_valid` and an empty queue: ignored, and `resolve_error` sets and stays set until reset.
- Simultaneous push and matching resolve: both happen and the count is unchanged. When full, `pred_ready`=0 even if a pop occurs that cycle.
- During the `update` cycle, `res_valid` is ignored.

## Timing
- Reset (async assert, sync deassert by the environment): queue empty; `inflight`=0, `update`=0, `flush`=0, `update_taken`=0, `wrong_PC`/`update_PC`/`update_branch_PC`=0, `resolve_error`=0, `pred_ready`=1.
- All outputs except `pred_ready` are registered. Resolve in cycle N gives `update` in N+1.
- Reset asserted mid-operation clears everything immediately, including a pending update.

## Structure
- Package `branch_pkg`: `bp_entry_t` {pc, pred_next}, shared `INVALID_PC` constant, function `bp_correct_next(pc, is_branch, taken, target)`.
- Sub-module `bp_fifo`: DEPTH-entry circular FIFO with push, pop, synchronous `clear`, and count, using wrap-around pointers one bit wider than the index.
- Top level holds the compare and update registers.

## Test plan
- Push PC 0x100 with pred 0x104, then resolve not-branch → no `update`, `inflight` 1→0.
- Push PC 0x200 with pred 0x204, then resolve branch taken to 0x300 → next cycle `update`=`flush`=1, `wrong_PC`=0x204, `update_PC`=0x300, `update_taken`=1, `update_branch_PC`=0x200.
- Push 3 entries, second mispredicted (pred 0x500, actual 0x10C) → single update, queue cleared; a push in the mispredict and update cycles sees `pred_ready`=0 and `inflight` stays 0.
- Fill DEPTH=8 entries → `pred_ready`=0 and a 9th push is dropped; simultaneous push and matching resolve at 7 entries keeps `inflight`=7.
- `res_valid` with queue empty → `resolve_error`=1 and stays 1. Push with `pred_PC`=0xfafafafa → `inflight` unchanged.
- PC 0xfffffffc with pred 0x0, not-branch → match (wrap). Assert `rstn`=0 in the cycle before an expected update → `update` never asserts, all outputs 0.
